// File: rtl/prog_seq_pkg.sv
// Shared types and default constants for the program run-control sequencer.
package prog_seq_pkg;

    localparam int unsigned PC_W_DEF      = 11;
    localparam int unsigned CNT_W_DEF     = 16;
    localparam int unsigned NUM_PROGS_DEF = 3;

    localparam int unsigned BASE0_DEF = 0;
    localparam int unsigned BASE1_DEF = 256;
    localparam int unsigned BASE2_DEF = 512;
    localparam int unsigned BASE3_DEF = 768;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    always_ff @(posedge Clk) begin
        if (Reset || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/prog_sequencer.sv
// Start/Done run-control sequencer driving PC hold/load and program rotation.
// Optional watchdog timeout enabled by defining PROG_SEQ_WATCHDOG_EN.
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int unsigned     PC_W      = PC_W_DEF,
    parameter int unsigned     CNT_W     = CNT_W_DEF,
    parameter int unsigned     NUM_PROGS = NUM_PROGS_DEF,
    parameter logic [PC_W-1:0] BASE0     = PC_W'(BASE0_DEF),
    parameter logic [PC_W-1:0] BASE1     = PC_W'(BASE1_DEF),
    parameter logic [PC_W-1:0] BASE2     = PC_W'(BASE2_DEF),
    parameter logic [PC_W-1:0] BASE3     = PC_W'(BASE3_DEF)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt_Req,
    output logic             Pc_Hold,
    output logic             Pc_Load,
    output logic [PC_W-1:0]  Pc_Base,
    output logic [1:0]       Prog_Sel,
    output logic             Done,
    output logic             Timeout,
    output logic [CNT_W-1:0] Cycle_Count
);

    seq_state_t state, next_state;

`ifdef PROG_SEQ_WATCHDOG_EN
    // Trip one count early so DONE lands on the same edge the counter hits all-ones.
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] WD_TRIP = CNT_MAX - CNT_W'(1);
    logic wd_trip;
    logic timeout_q;

    assign wd_trip = (Cycle_Count >= WD_TRIP);
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:  if (Start) next_state = ST_ARMED;
            ST_ARMED: if (!Start) next_state = ST_LOAD;
            ST_LOAD:  next_state = ST_RUN;
            ST_RUN: begin
                if (Start) begin
                    next_state = ST_ARMED;
                end else if (Halt_Req) begin
                    next_state = ST_DONE;
`ifdef PROG_SEQ_WATCHDOG_EN
                end else if (wd_trip) begin
                    next_state = ST_DONE;
`endif
                end
            end
            ST_DONE:  if (Start) next_state = ST_ARMED;
            default:  next_state = ST_IDLE;
        endcase
    end

    assign Pc_Hold = (state == ST_IDLE) || (state == ST_ARMED) || (state == ST_DONE);
    assign Pc_Load = (state == ST_LOAD);
    assign Done    = (state == ST_DONE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Prog_Sel <= '0;
        end else if ((state == ST_DONE) && Start) begin
            if (Prog_Sel == 2'(NUM_PROGS - 1)) begin
                Prog_Sel <= '0;
            end else begin
                Prog_Sel <= Prog_Sel + 2'd1;
            end
        end
    end

    always_comb begin
        unique case (Prog_Sel)
            2'd0:    Pc_Base = BASE0;
            2'd1:    Pc_Base = BASE1;
            2'd2:    Pc_Base = BASE2;
            default: Pc_Base = BASE3;
        endcase
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cycle_cnt (
        .Clk    (Clk),
        .Reset  (Reset),
        .clear  (state == ST_LOAD),
        .enable (state == ST_RUN),
        .count  (Cycle_Count)
    );

`ifdef PROG_SEQ_WATCHDOG_EN
    always_ff @(posedge Clk) begin
        if (Reset || (state == ST_LOAD)) begin
            timeout_q <= 1'b0;
        end else if ((state == ST_RUN) && !Start && !Halt_Req && wd_trip) begin
            timeout_q <= 1'b1;
        end
    end

    assign Timeout = timeout_q;
`else
    assign Timeout = 1'b0;
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Randomized self-checking bench for prog_sequencer; expected values come from a
// transaction-level model (program index, run length, how each run ends).
module tb_prog_sequencer;

    localparam int unsigned PC_W   = 11;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned NPROGS = 3;
    localparam int unsigned CMAX   = 15;

    logic             Clk = 1'b0;
    logic             Reset, Start, Halt_Req;
    logic             Pc_Hold, Pc_Load, Done, Timeout;
    logic [PC_W-1:0]  Pc_Base;
    logic [1:0]       Prog_Sel;
    logic [CNT_W-1:0] Cycle_Count;

    int unsigned n_checks = 0;
    int unsigned n_bad    = 0;

    int unsigned exp_base [4] = '{0, 256, 512, 768};
    int unsigned exp_sel  = 0;
    bit          in_done  = 0;
    bit          exp_to   = 0;

    prog_sequencer #(
        .PC_W      (PC_W),
        .CNT_W     (CNT_W),
        .NUM_PROGS (NPROGS)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Halt_Req    (Halt_Req),
        .Pc_Hold     (Pc_Hold),
        .Pc_Load     (Pc_Load),
        .Pc_Base     (Pc_Base),
        .Prog_Sel    (Prog_Sel),
        .Done        (Done),
        .Timeout     (Timeout),
        .Cycle_Count (Cycle_Count)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_reset_vals();
        check_eq("rst_hold",  Pc_Hold, 1);
        check_eq("rst_load",  Pc_Load, 0);
        check_eq("rst_done",  Done, 0);
        check_eq("rst_to",    Timeout, 0);
        check_eq("rst_sel",   Prog_Sel, 0);
        check_eq("rst_count", Cycle_Count, 0);
        check_eq("rst_base",  Pc_Base, exp_base[0]);
        exp_sel = 0;
        in_done = 0;
        exp_to  = 0;
    endtask

    // Arm, release Start, load; returns with the first RUN cycle visible.
    task automatic launch(input int unsigned hold);
        Start = 1'b1;
        tick();
        if (in_done) exp_sel = (exp_sel + 1) % NPROGS;
        in_done = 0;
        check_eq("armed_hold", Pc_Hold, 1);
        check_eq("armed_done", Done, 0);
        check_eq("armed_sel",  Prog_Sel, exp_sel);
        check_eq("armed_to",   Timeout, exp_to);
        for (int unsigned i = 1; i < hold; i++) begin
            Halt_Req = 1'($urandom_range(0, 1));
            tick();
        end
        Halt_Req = 1'b0;
        Start    = 1'b0;
        tick();
        check_eq("load_pulse", Pc_Load, 1);
        check_eq("load_hold",  Pc_Hold, 0);
        check_eq("load_base",  Pc_Base, exp_base[exp_sel]);
        check_eq("load_sel",   Prog_Sel, exp_sel);
        tick();
        exp_to = 0;
        check_eq("run_load",  Pc_Load, 0);
        check_eq("run_hold",  Pc_Hold, 0);
        check_eq("run_cnt0",  Cycle_Count, 0);
        check_eq("run_to",    Timeout, 0);
    endtask

    // kind: 0 = halt, 1 = Start abort, 2 = Start and halt together.
    task automatic run_prog(input int unsigned hold, input int unsigned run_n, input int unsigned kind);
        launch(hold);
        for (int unsigned i = 1; i < run_n; i++) begin
            tick();
            check_eq("run_count", Cycle_Count, i);
            check_eq("run_done",  Done, 0);
        end
        case (kind)
            0: begin
                Halt_Req = 1'b1;
                tick();
                Halt_Req = 1'b0;
                in_done  = 1;
                check_eq("halt_done",  Done, 1);
                check_eq("halt_hold",  Pc_Hold, 1);
                check_eq("halt_count", Cycle_Count, run_n);
                check_eq("halt_to",    Timeout, 0);
                Halt_Req = 1'b1;
                tick();
                Halt_Req = 1'b0;
                check_eq("done_level", Done, 1);
                check_eq("done_frozen", Cycle_Count, run_n);
            end
            1: begin
                Start = 1'b1;
                tick();
                check_eq("abort_done",  Done, 0);
                check_eq("abort_hold",  Pc_Hold, 1);
                check_eq("abort_sel",   Prog_Sel, exp_sel);
                check_eq("abort_count", Cycle_Count, run_n);
            end
            default: begin
                Start    = 1'b1;
                Halt_Req = 1'b1;
                tick();
                Halt_Req = 1'b0;
                check_eq("both_done", Done, 0);
                check_eq("both_hold", Pc_Hold, 1);
                tick();
                check_eq("both_done2", Done, 0);
                check_eq("both_count", Cycle_Count, run_n);
            end
        endcase
    endtask

    task automatic run_watchdog();
        bit stopped = 0;
        launch(1);
        for (int unsigned i = 1; i <= 20; i++) begin
            if (!stopped) begin
                tick();
`ifdef PROG_SEQ_WATCHDOG_EN
                if (i < CMAX) begin
                    check_eq("wd_count", Cycle_Count, i);
                    check_eq("wd_done",  Done, 0);
                end else begin
                    check_eq("wd_trip_done",  Done, 1);
                    check_eq("wd_trip_to",    Timeout, 1);
                    check_eq("wd_trip_count", Cycle_Count, CMAX);
                    stopped = 1;
                end
`else
                check_eq("sat_count", Cycle_Count, (i < CMAX) ? i : CMAX);
                check_eq("sat_done",  Done, 0);
                check_eq("sat_hold",  Pc_Hold, 0);
                check_eq("sat_to",    Timeout, 0);
`endif
            end
        end
`ifdef PROG_SEQ_WATCHDOG_EN
        exp_to  = 1;
        in_done = 1;
        tick();
        check_eq("wd_to_held", Timeout, 1);
        check_eq("wd_done_held", Done, 1);
`else
        Halt_Req = 1'b1;
        tick();
        Halt_Req = 1'b0;
        in_done  = 1;
        check_eq("sat_halt_done",  Done, 1);
        check_eq("sat_halt_count", Cycle_Count, CMAX);
`endif
    endtask

    initial begin
        Reset    = 1'b1;
        Start    = 1'b0;
        Halt_Req = 1'b0;
        tick();
        tick();
        check_reset_vals();
        Reset = 1'b0;
        tick();
        check_eq("idle_hold", Pc_Hold, 1);

        run_prog(3, 10, 0);
        run_prog(2, 5, 0);
        run_prog(1, 7, 0);
        run_prog(1, 4, 0);
        run_prog(1, 6, 1);
        run_prog(1, 3, 0);
        run_prog(1, 4, 2);
        run_prog(1, 2, 0);

        for (int unsigned n = 0; n < 12; n++) begin
            run_prog($urandom_range(1, 4), $urandom_range(1, 14), $urandom_range(0, 2));
        end

        run_watchdog();
        run_prog(1, 5, 0);

        launch(2);
        tick();
        tick();
        Reset = 1'b1;
        tick();
        check_reset_vals();
        Reset = 1'b0;
        tick();
        run_prog(1, 3, 0);
        Reset = 1'b1;
        tick();
        check_reset_vals();
        Reset = 1'b0;
        tick();
        run_prog(2, 2, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
